// File: rtl/uart_rx_pkg.sv
// Shared encodings for the UART RX core: FSM state codes, DATA_LEN limits and parity types.
package uart_rx_pkg;

  // Gray-style codes: each step of the normal frame flow flips a single bit.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b010,
    ST_STOP   = 3'b110,
    ST_DONE   = 3'b111
  } state_e;

  localparam logic [3:0] DATA_LEN_MIN = 4'd5;
  localparam logic [3:0] DATA_LEN_MAX = 4'd9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] cap);
    return ((len < DATA_LEN_MIN) || (len > cap)) ? cap : len;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// 3-tap majority sampler: taps RX_IN at P/2-1, P/2, P/2+1 and registers the vote at P/2+2.
module uart_rx_sampler #(
  parameter int PRESCALER_WIDTH = 6
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic                       rx_in,
  input  logic [PRESCALER_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALER_WIDTH-1:0] prescale,
  output logic                       maj,
  output logic                       strobe,
  output logic                       bit_val
);

  localparam logic [PRESCALER_WIDTH-1:0] ONE = PRESCALER_WIDTH'(1);
  localparam logic [PRESCALER_WIDTH-1:0] TWO = PRESCALER_WIDTH'(2);

  logic [PRESCALER_WIDTH-1:0] half;
  logic [2:0]                 samp_q, samp_d;
  logic                       bit_q, bit_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    half   = prescale >> 1;
    samp_d = samp_q;
    if (en) begin
      if (edge_cnt == half - ONE) samp_d[0] = rx_in;
      if (edge_cnt == half)       samp_d[1] = rx_in;
      if (edge_cnt == half + ONE) samp_d[2] = rx_in;
    end
    maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    strobe = en && (edge_cnt == half + TWO);
    bit_d  = strobe ? maj : bit_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_q <= 3'b111;
      bit_q  <= 1'b1;
    end else begin
      samp_q <= samp_d;
      bit_q  <= bit_d;
    end
  end

  assign bit_val = bit_q;

endmodule

// File: rtl/uart_rx_core_gen2.sv
// UART receive core: FSM, edge/bit counters, deserializer, parity and stop checkers.
// Optional break detection is enabled with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_core_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int PRESCALER_WIDTH = 6
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       RX_IN,
  input  logic [PRESCALER_WIDTH-1:0] PRESCALE,
  input  logic [3:0]                 DATA_LEN,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  input  logic                       STOP2,
  output logic [DATA_WIDTH-1:0]      P_DATA,
  output logic                       Data_Valid,
  output logic                       par_err,
  output logic                       stop_err,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                       break_det,
`endif
  output logic                       busy
);

  localparam logic [PRESCALER_WIDTH-1:0] P_ONE  = PRESCALER_WIDTH'(1);
  localparam logic [PRESCALER_WIDTH-1:0] P_TWO  = PRESCALER_WIDTH'(2);
  localparam logic [PRESCALER_WIDTH-1:0] P_FOUR = PRESCALER_WIDTH'(4);
  localparam logic [3:0] LEN_CAP =
    (4'(DATA_WIDTH) > DATA_LEN_MAX) ? DATA_LEN_MAX : 4'(DATA_WIDTH);

  state_e                     state_q, state_d;
  logic [PRESCALER_WIDTH-1:0] edge_q, edge_d, p_q, p_d;
  logic [3:0]                 bit_cnt_q, bit_cnt_d, len_q, len_d;
  logic                       par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0]      shift_q, shift_d, pdata_q, pdata_d;
  logic                       perr_q, perr_d, serr_q, serr_d;
  logic                       dv_q, dv_d, pe_q, pe_d, se_q, se_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                       zero_q, zero_d, brk_wait_q, brk_wait_d, brk_q, brk_d, zero_now;
`endif

  logic       active, p_legal, edge_last, edge_stop, go_start, start_bit, serr_now, exp_par;
  logic       maj, strobe, bit_val;
  logic [3:0] first_stop, last_stop;

  assign active     = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign p_legal    = (PRESCALE >= P_FOUR) && !PRESCALE[0];
  assign edge_last  = (edge_q == p_q - P_ONE);
  assign edge_stop  = (edge_q == p_q - P_TWO);
  assign first_stop = len_q + 4'(par_en_q) + 4'd1;
  assign last_stop  = first_stop + 4'(stop2_q);
  // The vote lands at P/2+2, which can coincide with the start decision edge.
  assign start_bit  = strobe ? maj : bit_val;

  uart_rx_sampler #(.PRESCALER_WIDTH(PRESCALER_WIDTH)) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .en       (active),
    .rx_in    (RX_IN),
    .edge_cnt (edge_q),
    .prescale (p_q),
    .maj      (maj),
    .strobe   (strobe),
    .bit_val  (bit_val)
  );

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_cnt_d = bit_cnt_q;
    p_d       = p_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    serr_d    = serr_q;
    pdata_d   = pdata_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    go_start  = 1'b0;
    exp_par   = 1'b0;
    serr_now  = serr_q | (strobe & ~maj);
`ifdef UART_RX_BREAK_DETECT_EN
    zero_d     = zero_q;
    brk_wait_d = brk_wait_q;
    brk_d      = 1'b0;
    zero_now   = zero_q & ~(strobe & maj & (bit_cnt_q == first_stop));
    if (strobe && maj && ((state_q != ST_STOP) || (bit_cnt_q == first_stop))) zero_d = 1'b0;
`endif

    if (active) begin
      if (edge_last) begin
        edge_d    = '0;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        edge_d = edge_q + P_ONE;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_wait_q) begin
          if (RX_IN) brk_wait_d = 1'b0;
        end else
`endif
        if (!RX_IN && p_legal) go_start = 1'b1;
      end
      ST_START: begin
        if (edge_last) state_d = start_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (strobe) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (edge_last && (bit_cnt_q == len_q)) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        unique case (par_typ_q)
          PAR_EVEN: exp_par = ^shift_q;
          PAR_ODD:  exp_par = ~(^shift_q);
        endcase
        if (strobe && (maj != exp_par)) perr_d = 1'b1;
        if (edge_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (strobe && !maj) serr_d = 1'b1;
        // Exit one tick early so a back-to-back start edge is not missed.
        if (edge_stop && (bit_cnt_q == last_stop)) begin
          state_d = ST_DONE;
          pe_d    = perr_q;
          se_d    = serr_now;
          dv_d    = !perr_q && !serr_now;
`ifdef UART_RX_BREAK_DETECT_EN
          if (zero_now) begin
            brk_d = 1'b1;
            se_d  = 1'b0;
            dv_d  = 1'b0;
          end
`endif
          if (dv_d) pdata_d = shift_q >> (4'(DATA_WIDTH) - len_q);
        end
      end
      ST_DONE: begin
        if (!RX_IN && p_legal) go_start = 1'b1;
        else                   state_d  = ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_q) begin
          go_start   = 1'b0;
          state_d    = ST_IDLE;
          brk_wait_d = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_start) begin
      state_d   = ST_START;
      edge_d    = '0;
      bit_cnt_d = '0;
      p_d       = PRESCALE;
      len_d     = clamp_len(DATA_LEN, LEN_CAP);
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2;
      shift_d   = '0;
      perr_d    = 1'b0;
      serr_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_d    = 1'b1;
`endif
    end
  end

  // NOTE: the shift register is reset too, so P_DATA zero-fill never depends on power-up contents.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      edge_q     <= '0;
      bit_cnt_q  <= '0;
      p_q        <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q     <= 1'b0;
      brk_wait_q <= 1'b0;
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_cnt_q  <= bit_cnt_d;
      p_q        <= p_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q     <= zero_d;
      brk_wait_q <= brk_wait_d;
      brk_q      <= brk_d;
`endif
    end
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign par_err    = pe_q;
  assign stop_err   = se_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det  = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_core_gen2.sv
// Directed bench for uart_rx_core_gen2: frame vector table plus hand-written corner sequences.
module tb_uart_rx_core_gen2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd16;
  logic [3:0] data_len = 4'd8;
  logic       par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stop_err, busy;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       break_det;
  int         brk_tot = 0;
`endif

  uart_rx_core_gen2 #(.DATA_WIDTH(8), .PRESCALER_WIDTH(6)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx_in),
    .PRESCALE   (prescale),
    .DATA_LEN   (data_len),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STOP2      (stop2),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det  (break_det),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dv_tot = 0, pe_tot = 0, se_tot = 0;
  logic [7:0] rx_words[$];

  // Pulse monitor: counts every high cycle, so a pulse wider than one cycle counts more than once.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_tot <= dv_tot + 1;
      rx_words.push_back(p_data);
    end
    if (par_err)  pe_tot <= pe_tot + 1;
    if (stop_err) se_tot <= se_tot + 1;
`ifdef UART_RX_BREAK_DETECT_EN
    if (break_det) brk_tot <= brk_tot + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int p, input logic [3:0] len, input logic pen,
                         input logic ptyp, input logic st2);
    prescale = p[5:0];
    data_len = len;
    par_en   = pen;
    par_typ  = ptyp;
    stop2    = st2;
  endtask

  task automatic send_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int p, input int nbits, input logic [8:0] data,
                            input logic has_par, input logic pbit, input logic s1,
                            input logic has_s2, input logic s2);
    send_bit(1'b0, p);
    for (int i = 0; i < nbits; i++) send_bit(data[i], p);
    if (has_par) send_bit(pbit, p);
    send_bit(s1, p);
    if (has_s2) send_bit(s2, p);
    rx_in = 1'b1;
  endtask

  typedef struct {
    string      name;
    int         p;
    logic [3:0] len;
    logic       pen;
    logic       ptyp;
    logic       st2;
    int         nbits;
    logic [8:0] data;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic       brk;
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_se;
    logic [7:0] exp_pd;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0, pe0, se0, ws;
    logic exp_se;
`ifdef UART_RX_BREAK_DETECT_EN
    int bk0;
`endif

    //          name          p   len   pen   ptyp  st2   nb data    pbit  s1    s2    brk   dv    pe    se    pdata
    vecs[0] = '{"a5_even",    16, 4'd8, 1'b1, 1'b0, 1'b0, 8, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{"odd_bad",    8,  4'd7, 1'b1, 1'b1, 1'b0, 7, 9'h055, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{"stop2_bad",  16, 4'd8, 1'b0, 1'b0, 1'b1, 8, 9'h03C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{"len5_odd",   32, 4'd5, 1'b1, 1'b1, 1'b0, 5, 9'h013, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h13};
    vecs[4] = '{"len_oob",    8,  4'd3, 1'b0, 1'b0, 1'b0, 8, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[5] = '{"both_err",   16, 4'd6, 1'b1, 1'b0, 1'b0, 6, 9'h02B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3};
    vecs[6] = '{"break",      8,  4'd8, 1'b0, 1'b0, 1'b0, 8, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3};
    vecs[7] = '{"even_p8",    8,  4'd8, 1'b1, 1'b0, 1'b0, 8, 9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[8] = '{"bad_presc",  15, 4'd8, 1'b0, 1'b0, 1'b0, 8, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[9] = '{"stop2_odd",  16, 4'd8, 1'b1, 1'b1, 1'b1, 8, 9'h0FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};

    repeat (3) @(negedge clk);
    check("rst_p_data",   32'(p_data),     32'h0);
    check("rst_valid",    32'(data_valid), 32'h0);
    check("rst_par_err",  32'(par_err),    32'h0);
    check("rst_stop_err", 32'(stop_err),   32'h0);
    check("rst_busy",     32'(busy),       32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      set_cfg(vecs[i].p, vecs[i].len, vecs[i].pen, vecs[i].ptyp, vecs[i].st2);
      dv0 = dv_tot; pe0 = pe_tot; se0 = se_tot;
`ifdef UART_RX_BREAK_DETECT_EN
      bk0 = brk_tot;
`endif
      send_frame(vecs[i].p, vecs[i].nbits, vecs[i].data, vecs[i].pen, vecs[i].pbit,
                 vecs[i].s1, vecs[i].st2, vecs[i].s2);
      repeat (3 * vecs[i].p) @(negedge clk);
      exp_se = vecs[i].exp_se;
`ifdef UART_RX_BREAK_DETECT_EN
      if (vecs[i].brk) exp_se = 1'b0;
      check({vecs[i].name, "_brk"}, 32'(brk_tot - bk0), 32'(vecs[i].brk));
`endif
      check({vecs[i].name, "_dv"},   32'(dv_tot - dv0), 32'(vecs[i].exp_dv));
      check({vecs[i].name, "_pe"},   32'(pe_tot - pe0), 32'(vecs[i].exp_pe));
      check({vecs[i].name, "_se"},   32'(se_tot - se0), 32'(exp_se));
      check({vecs[i].name, "_pd"},   32'(p_data),       32'(vecs[i].exp_pd));
      check({vecs[i].name, "_busy"}, 32'(busy),         32'h0);
    end

    // Start glitch: 3-tick low pulse must be rejected without any pulse.
    set_cfg(16, 4'd8, 1'b0, 1'b0, 1'b0);
    dv0 = dv_tot; pe0 = pe_tot; se0 = se_tot;
    send_bit(1'b0, 3);
    send_bit(1'b1, 4);
    check("glitch_busy_mid", 32'(busy), 32'h1);
    repeat (24) @(negedge clk);
    check("glitch_busy_end", 32'(busy), 32'h0);
    check("glitch_pulses", 32'((dv_tot - dv0) + (pe_tot - pe0) + (se_tot - se0)), 32'h0);
    check("glitch_pd", 32'(p_data), 32'hFF);

    // Back-to-back frames with no idle gap.
    set_cfg(32, 4'd8, 1'b0, 1'b0, 1'b0);
    dv0 = dv_tot; ws = rx_words.size();
    send_frame(32, 8, 9'h012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(32, 8, 9'h034, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    check("b2b_count", 32'(dv_tot - dv0), 32'h2);
    check("b2b_word0", 32'(rx_words[ws]),     32'h12);
    check("b2b_word1", 32'(rx_words[ws + 1]), 32'h34);

    // Config changed mid-frame must not affect the frame in flight.
    set_cfg(16, 4'd8, 1'b0, 1'b0, 1'b0);
    dv0 = dv_tot; pe0 = pe_tot;
    send_bit(1'b0, 16);
    set_cfg(8, 4'd5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h96;
      send_bit(w[i], 16);
    end
    send_bit(1'b1, 16);
    repeat (48) @(negedge clk);
    check("latch_dv", 32'(dv_tot - dv0), 32'h1);
    check("latch_pe", 32'(pe_tot - pe0), 32'h0);
    check("latch_pd", 32'(p_data), 32'h96);

    // Reset in the middle of DATA, then a clean frame.
    set_cfg(16, 4'd8, 1'b0, 1'b0, 1'b0);
    dv0 = dv_tot; pe0 = pe_tot; se0 = se_tot;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    check("rst_mid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_pd", 32'(p_data), 32'h0);
    rx_in = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(16, 8, 9'h05A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (48) @(negedge clk);
    check("rst_mid_dv", 32'(dv_tot - dv0), 32'h1);
    check("rst_mid_errs", 32'((pe_tot - pe0) + (se_tot - se0)), 32'h0);
    check("rst_mid_pd_after", 32'(p_data), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
